regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of a RISC-V PE register file (an array of Register cells, each with clock/r_enable/reset/data_in/data_out) between NUM_REQ requesters (ALU writeback, load unit, CGRA neighbour links).
- Arbitrates round-robin with a valid/ready handshake, registers the winner, then drives a one-hot r_enable vector and a shared data_in bus for exactly one cycle.
- Enforces x0 read-only and supports a hold (stall) input.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8)
- NUM_REGS, 32, number of Register cells driven
- DATA_W, 32, register width
- ADDR_W, 5, register index width; clog2(NUM_REGS)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clock edge, asserted when 0
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  one-hot grant; the transfer occurs when valid and ready are both high
- req_addr  in  NUM_REQ*ADDR_W  packed destination indices; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing as req_addr
- hold  in  1  stall; blocks new grants
- reg_enable  out  NUM_REGS  one-hot r_enable to the Register cells
- reg_wdata  out  DATA_W  shared data_in bus to all Register cells
- last_grant  out  clog2(NUM_REQ)  index of the most recently accepted requester
- busy  out  1  write stage holds a pending write

Behaviour:
- Reset (reset==0 at an edge):
  - req_ready=0, reg_enable=0, reg_wdata=0, last_grant=0, busy=0.
  - Round-robin pointer = 0.
  - Any in-flight write is discarded.
- Stage A, arbitrate (combinational req_ready):
  - When hold==0, req_ready is one-hot to the first valid requester searching upward from (last_grant+1) mod NUM_REQ, wrapping.
  - req_ready=0 when hold==1, when reset==0, or when no request is valid.
  - Requesters must hold valid/addr/data stable until accepted.
- Stage B, write register (sequential):
  - On an edge where a handshake occurs: latch addr and data, set last_grant to the winner, busy=1.
  - In the following cycle: reg_enable[addr]=1 and reg_wdata=data, with exactly one bit set. The Register cell loads at the end of that cycle.
  - Latency: handshake at edge N → reg_enable high for cycle N..N+1 → register data_out valid after edge N+1.
- Throughput: one write per cycle; back-to-back handshakes keep busy=1 continuously.
- With no handshake at an edge: reg_enable=0 and busy=0 next cycle; reg_wdata holds its last value.
- addr==0:
  - The handshake completes normally (ready asserted, last_grant updated).
  - reg_enable stays all-zero and busy=1 for that cycle (x0 is never written).
- addr ≥ NUM_REGS: handshake accepted, no enable asserted (dropped silently).
- hold asserted mid-stream: the already-latched write still completes; no new grants are issued until hold==0.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Single requester: granted every cycle.

Optional Feature:
- Macro: REGFILE_WRITE_ARBITER_BYPASS_EN.
- When defined, add ports:
  - rd_addr in ADDR_W
  - rd_reg_data in DATA_W (muxed Register data_out)
  - rd_data out DATA_W
- rd_data = reg_wdata when busy && enabled-write addr==rd_addr && rd_addr!=0; otherwise rd_data = rd_reg_data. This is combinational forwarding of the in-flight write.
- When the macro is undefined, these ports and the mux are absent and readers see new data one cycle later.

Decomposition:
- Package regfile_pkg holds:
  - constants for default DATA_W, NUM_REGS, ADDR_W, X0_ADDR=0
  - a write-request struct typedef (addr, data)
- Sub-module rr_arbiter: parameter N; inputs req[N], en, last[clog2 N]; output one-hot gnt[N]. It is purely combinational and unit-testable separately.

Test Plan:
1. Reset held low 2 cycles with req_valid=4'b1111 → req_ready=0, reg_enable=0, busy=0 throughout. Release reset → first grant goes to requester 1 (pointer 0, search starts at 1).
2. Only requester 2 valid, addr=5, data=32'hA5A5A5A5 → req_ready=4'b0100 for one cycle; next cycle reg_enable=32'h00000020, reg_wdata=A5A5A5A5, busy=1; following cycle busy=0.
3. All four valid for 8 cycles with distinct addrs 1..4 → grant order 1,2,3,0,1,2,3,0; reg_enable one-hot matches each addr one cycle after its grant.
4. Requester 0 writes addr=0, data=32'h12345678 → handshake completes and last_grant=0; reg_enable stays 0 on every cycle.
5. Back-to-back grants with hold raised one cycle after a handshake → the latched write is still issued; req_ready=0 while hold=1; grants resume at the next requester after hold drops.
6. With REGFILE_WRITE_ARBITER_BYPASS_EN defined: write addr=7, data=5A5A5A5A, rd_addr=7 in the enable cycle → rd_data=5A5A5A5A. With rd_addr=0 instead → rd_data=rd_reg_data.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the register-file write path.
//   DEF_DATA_W   : default register width
//   DEF_NUM_REGS : default number of Register cells
//   DEF_ADDR_W   : default register index width
//   X0_ADDR      : index of the hard-wired zero register
//   wr_req_t     : one write request (destination index + data)
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int X0_ADDR      = 0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a winner starts
// one position above the previous winner and wraps around.
// Ports:
//   req  [N]          : request vector
//   en                : grant enable; no grant is produced when low
//   last [clog2(N)]   : index of the previous winner
//   gnt  [N]          : one-hot grant (all-zero when disabled or idle)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt
);

    logic [LW-1:0] w_idx;
    logic          w_found;

    // Walk the requesters starting just above the last winner; first hit wins.
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = LW'((int'(last) + 1 + k) % N);
            if (en && !w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single write port of a register file between NUM_REQ
// requesters. A round-robin grant (req_ready) is issued combinationally,
// the winning request is registered on the handshake edge, and in the
// following cycle a one-hot reg_enable plus shared reg_wdata drive the
// Register cells for exactly one cycle. Register x0 is never enabled and
// out-of-range indices are dropped after a normal handshake.
// Optional feature macro: REGFILE_WRITE_ARBITER_BYPASS_EN adds combinational
// forwarding of the in-flight write onto a read port.
// Ports:
//   clock       : rising-edge clock
//   reset       : synchronous, active-low reset
//   req_valid   : per-requester write request
//   req_ready   : one-hot grant, transfer when valid & ready
//   req_addr    : packed destination indices, requester i at [i*ADDR_W +: ADDR_W]
//   req_data    : packed write data, requester i at [i*DATA_W +: DATA_W]
//   hold        : stall, blocks new grants
//   reg_enable  : one-hot r_enable to the Register cells
//   reg_wdata   : shared data_in bus
//   last_grant  : index of the most recently accepted requester
//   busy        : write stage holds a pending write
//   rd_addr     : (bypass) read index
//   rd_reg_data : (bypass) muxed Register data_out
//   rd_data     : (bypass) forwarded read data
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic                        hold,
    output logic [NUM_REGS-1:0]         reg_enable,
    output logic [DATA_W-1:0]           reg_wdata,
    output logic [$clog2(NUM_REQ)-1:0]  last_grant,
    output logic                        busy
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]           rd_addr,
    input  logic [DATA_W-1:0]           rd_reg_data,
    output logic [DATA_W-1:0]           rd_data
`endif
);

    localparam int LW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]  w_gnt;
    logic                w_arb_en;
    logic                w_hs;
    logic [LW-1:0]       w_win_idx;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_data;
    logic [NUM_REGS-1:0] w_dec;

    logic [NUM_REGS-1:0] r_reg_enable;
    logic [DATA_W-1:0]   r_reg_wdata;
    logic [LW-1:0]       r_last_grant;
    logic                r_busy;

    // Grants are suppressed during reset as well as during a stall.
    assign w_arb_en = reset & ~hold;

    rr_arbiter #(
        .N  (NUM_REQ),
        .LW (LW)
    ) u_rr_arbiter (
        .req  (req_valid),
        .en   (w_arb_en),
        .last (r_last_grant),
        .gnt  (w_gnt)
    );

    assign req_ready = w_gnt;
    // The arbiter only grants valid requesters, so any grant is a handshake.
    assign w_hs      = |w_gnt;

    // Select the index, address and data of the granted requester.
    always_comb begin
        w_win_idx  = '0;
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_win_idx  = LW'(i);
                w_win_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_win_data = req_data[i*DATA_W +: DATA_W];
            end else begin
                w_win_idx = w_win_idx;
            end
        end
    end

    // One-hot decode of the winner's index; x0 and out-of-range stay silent.
    always_comb begin
        w_dec = '0;
        if ((w_win_addr != ADDR_W'(X0_ADDR)) &&
            ({1'b0, w_win_addr} < (ADDR_W+1)'(NUM_REGS))) begin
            w_dec[w_win_addr] = 1'b1;
        end else begin
            w_dec = '0;
        end
    end

    // Write stage: capture the winner on a handshake, otherwise go idle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_reg_enable <= '0;
            r_reg_wdata  <= '0;
            r_last_grant <= '0;
            r_busy       <= 1'b0;
        end else if (w_hs) begin
            r_reg_enable <= w_dec;
            r_reg_wdata  <= w_win_data;
            r_last_grant <= w_win_idx;
            r_busy       <= 1'b1;
        end else begin
            // reg_wdata deliberately keeps its last value.
            r_reg_enable <= '0;
            r_busy       <= 1'b0;
        end
    end

    assign reg_enable = r_reg_enable;
    assign reg_wdata  = r_reg_wdata;
    assign last_grant = r_last_grant;
    assign busy       = r_busy;

`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    logic [ADDR_W-1:0] r_addr;

    // Destination of the in-flight write, used only for forwarding.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_addr <= '0;
        end else if (w_hs) begin
            r_addr <= w_win_addr;
        end else begin
            r_addr <= r_addr;
        end
    end

    // Forward the in-flight write when it really targets the read index.
    always_comb begin
        if (r_busy && (r_reg_enable != '0) && (r_addr == rd_addr) &&
            (rd_addr != ADDR_W'(X0_ADDR))) begin
            rd_data = r_reg_wdata;
        end else begin
            rd_data = rd_reg_data;
        end
    end
`endif

endmodule
